// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: PS/2 set-2 scancode decoder with held-key table,
// typematic repeat filter, press counter and overflow flag.
module ps2_key_tracker #(
  parameter int NKEYS   = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 din,
  input  logic                       din_valid,
  input  logic                       clr_ovf,
  output logic [7:0]                 key_code,
  output logic                       key_ext,
  output logic                       key_held_any,
  output logic [$clog2(NKEYS+1)-1:0] held_cnt,
  output logic                       evt_valid,
  output logic [7:0]                 evt_code,
  output logic                       evt_ext,
  output logic                       evt_break,
  output logic                       evt_repeat,
  output logic [CNT_W-1:0]           press_cnt,
  output logic                       overflow
);

  localparam int HW = $clog2(NKEYS+1);
  localparam int TW = $clog2(TIMEOUT+1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT-1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_E0   = 2'd1;
  localparam logic [1:0] S_F0   = 2'd2;
  localparam logic [1:0] S_E0F0 = 2'd3;

  logic [1:0]       state;
  logic [1:0]       nstate;
  logic [TW-1:0]    tcnt;
  logic [NKEYS-1:0] tv;
  logic [NKEYS-1:0] te;
  logic [7:0]       tc [NKEYS];

  logic             is_e0;
  logic             is_f0;
  logic             is_ack;
  logic             ev;
  logic             ev_brk;
  logic             ev_ext;
  logic [NKEYS-1:0] hit_vec;
  logic [NKEYS-1:0] free_vec;
  logic             hit;
  logic             full;
  logic             new_press;
  logic             ins;

  assign is_e0  = (din == 8'hE0);
  assign is_f0  = (din == 8'hF0);
  assign is_ack = (din == 8'hFA) || (din == 8'hAA) ||
                  (din == 8'hEE) || (din == 8'hFE);

  always_comb begin
    nstate = state;
    ev     = 1'b0;
    ev_brk = 1'b0;
    ev_ext = 1'b0;
    if (din_valid) begin
      unique case (state)
        S_IDLE: begin
          unique case (1'b1)
            is_e0:   nstate = S_E0;
            is_f0:   nstate = S_F0;
            is_ack:  nstate = S_IDLE;
            default: ev = 1'b1;
          endcase
        end
        S_E0: begin
          unique case (1'b1)
            is_f0:   nstate = S_E0F0;
            is_e0:   nstate = S_E0;
            default: begin
              ev     = 1'b1;
              ev_ext = 1'b1;
              nstate = S_IDLE;
            end
          endcase
        end
        S_F0: begin
          ev     = 1'b1;
          ev_brk = 1'b1;
          nstate = S_IDLE;
        end
        default: begin
          ev     = 1'b1;
          ev_brk = 1'b1;
          ev_ext = 1'b1;
          nstate = S_IDLE;
        end
      endcase
    end else if (state != S_IDLE && tcnt == TMAX) begin
      nstate = S_IDLE;
    end
  end

  always_comb begin
    for (int i = 0; i < NKEYS; i++) begin
      hit_vec[i] = tv[i] && (te[i] == ev_ext) &&
                   (tc[i] == din);
    end
  end

  // lowest clear bit of tv, one-hot
  assign free_vec  = ~tv & (tv + NKEYS'(1));
  assign hit       = |hit_vec;
  assign full      = ~|free_vec;
  assign new_press = ev && !ev_brk && !hit;
  assign ins       = new_press && !full;

  always_comb begin
    held_cnt = '0;
    for (int i = 0; i < NKEYS; i++) begin
      held_cnt = held_cnt + HW'(tv[i]);
    end
  end

  assign key_held_any = |tv;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      tcnt  <= '0;
    end else begin
      state <= nstate;
      if (din_valid || nstate == S_IDLE) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tv <= '0;
      te <= '0;
      for (int i = 0; i < NKEYS; i++) begin
        tc[i] <= '0;
      end
    end else if (ev) begin
      if (ev_brk) begin
        tv <= tv & ~hit_vec;
      end else if (ins) begin
        tv <= tv | free_vec;
        for (int i = 0; i < NKEYS; i++) begin
          if (free_vec[i]) begin
            te[i] <= ev_ext;
            tc[i] <= din;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_valid  <= 1'b0;
      evt_code   <= '0;
      evt_ext    <= 1'b0;
      evt_break  <= 1'b0;
      evt_repeat <= 1'b0;
      press_cnt  <= '0;
      key_code   <= '0;
      key_ext    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      evt_valid <= ev;
      if (ev) begin
        evt_code   <= din;
        evt_ext    <= ev_ext;
        evt_break  <= ev_brk;
        evt_repeat <= !ev_brk && hit;
      end
      if (new_press) begin
        press_cnt <= press_cnt + CNT_W'(1);
        key_code  <= din;
        key_ext   <= ev_ext;
      end
      if (new_press && full) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: directed + random scancode stream
// checked against a slot-list reference model.
module tb_ps2_key_tracker;

  localparam int NK = 4;
  localparam int CW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    din = 8'h00;
  logic          din_valid = 1'b0;
  logic          clr_ovf = 1'b0;
  logic [7:0]    key_code;
  logic          key_ext;
  logic          key_held_any;
  logic [2:0]    held_cnt;
  logic          evt_valid;
  logic [7:0]    evt_code;
  logic          evt_ext;
  logic          evt_break;
  logic          evt_repeat;
  logic [CW-1:0] press_cnt;
  logic          overflow;

  ps2_key_tracker #(.NKEYS(NK), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .clr_ovf(clr_ovf), .key_code(key_code), .key_ext(key_ext),
    .key_held_any(key_held_any), .held_cnt(held_cnt),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_ext(evt_ext),
    .evt_break(evt_break), .evt_repeat(evt_repeat),
    .press_cnt(press_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: pending prefix flags, idle gap, slot list
  bit          m_pfx, m_pext, m_pbrk;
  int          m_gap;
  bit          sv [NK];
  bit [8:0]    sk [NK];
  bit [7:0]    m_kc;
  bit          m_kx;
  bit [CW-1:0] m_press;
  bit          m_ovf;
  bit          m_ev;
  bit [7:0]    m_ec;
  bit          m_ex, m_eb, m_er;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pfx = 0; m_pext = 0; m_pbrk = 0; m_gap = 0;
    for (int i = 0; i < NK; i++) begin sv[i] = 0; sk[i] = '0; end
    m_kc = 0; m_kx = 0; m_press = 0; m_ovf = 0;
    m_ev = 0; m_ec = 0; m_ex = 0; m_eb = 0; m_er = 0;
  endtask

  function automatic int m_held();
    int n = 0;
    for (int i = 0; i < NK; i++) n += int'(sv[i]);
    return n;
  endfunction

  task automatic key_event(input bit ext, input bit brk,
                           input bit [7:0] code, output bit ovf_set);
    int found = -1;
    int slot = -1;
    ovf_set = 0;
    m_ev = 1; m_ec = code; m_ex = ext; m_eb = brk; m_er = 0;
    for (int i = 0; i < NK; i++)
      if (sv[i] && sk[i] == {ext, code}) found = i;
    if (brk) begin
      if (found >= 0) sv[found] = 0;
    end else if (found >= 0) begin
      m_er = 1;
    end else begin
      m_press = m_press + 1'b1;
      m_kc = code; m_kx = ext;
      for (int i = NK - 1; i >= 0; i--) if (!sv[i]) slot = i;
      if (slot >= 0) begin sv[slot] = 1; sk[slot] = {ext, code}; end
      else ovf_set = 1;
    end
  endtask

  task automatic model_step(input bit v, input bit [7:0] b,
                            input bit c);
    bit ovf_set = 0;
    m_ev = 0;
    if (v) begin
      m_gap = 0;
      if (m_pfx && m_pbrk) begin
        key_event(m_pext, 1'b1, b, ovf_set);
        m_pfx = 0; m_pext = 0; m_pbrk = 0;
      end else if (b == 8'hF0) begin
        m_pfx = 1; m_pbrk = 1;
      end else if (b == 8'hE0) begin
        m_pfx = 1; m_pext = 1;
      end else if (!m_pfx && (b == 8'hFA || b == 8'hAA ||
                              b == 8'hEE || b == 8'hFE)) begin
      end else begin
        key_event(m_pext, 1'b0, b, ovf_set);
        m_pfx = 0; m_pext = 0; m_pbrk = 0;
      end
    end else if (m_pfx) begin
      m_gap++;
      if (m_gap >= TO) begin
        m_pfx = 0; m_pext = 0; m_pbrk = 0; m_gap = 0;
      end
    end
    if (ovf_set) m_ovf = 1;
    else if (c) m_ovf = 0;
  endtask

  task automatic check_all(input string t);
    chk({t, ".evt_valid"}, 32'(evt_valid), 32'(m_ev));
    chk({t, ".evt_code"}, 32'(evt_code), 32'(m_ec));
    chk({t, ".evt_ext"}, 32'(evt_ext), 32'(m_ex));
    chk({t, ".evt_break"}, 32'(evt_break), 32'(m_eb));
    chk({t, ".evt_repeat"}, 32'(evt_repeat), 32'(m_er));
    chk({t, ".held_cnt"}, 32'(held_cnt), 32'(m_held()));
    chk({t, ".held_any"}, 32'(key_held_any), 32'(m_held() != 0));
    chk({t, ".press_cnt"}, 32'(press_cnt), 32'(m_press));
    chk({t, ".key_code"}, 32'(key_code), 32'(m_kc));
    chk({t, ".key_ext"}, 32'(key_ext), 32'(m_kx));
    chk({t, ".overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic tick(input bit v, input logic [7:0] b, input bit c,
                      input string t);
    din_valid = v; din = b; clr_ovf = c;
    model_step(v, b, c);
    @(negedge clk);
    check_all(t);
    din_valid = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input string t);
    tick(1'b1, b, 1'b0, t);
  endtask

  task automatic idle(input int n, input string t);
    repeat (n) tick(1'b0, 8'($urandom), 1'b0, t);
  endtask

  task automatic zero_check(input string t);
    chk({t, ".z_evt_valid"}, 32'(evt_valid), 0);
    chk({t, ".z_evt_code"}, 32'(evt_code), 0);
    chk({t, ".z_evt_flags"}, 32'({evt_ext, evt_break, evt_repeat}), 0);
    chk({t, ".z_held"}, 32'({key_held_any, held_cnt}), 0);
    chk({t, ".z_press"}, 32'(press_cnt), 0);
    chk({t, ".z_key"}, 32'({key_ext, key_code}), 0);
    chk({t, ".z_ovf"}, 32'(overflow), 0);
  endtask

  // asserts rst away from the clock edge and checks outputs at once
  task automatic do_reset(input string t);
    #2 rst = 1'b0;
    #1 zero_check(t);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [7:0] pool [10] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
                           8'h75, 8'hE0, 8'hF0, 8'hFA, 8'hE1};

  initial begin
    model_reset();
    #12 zero_check("por");
    @(negedge clk);
    rst = 1'b1;

    send(8'h1C, "mk1c");
    chk("mk1c.press", 32'(press_cnt), 1);
    send(8'h1C, "rep1");
    chk("rep1.flag", 32'(evt_repeat), 1);
    send(8'h1C, "rep2");
    send(8'hF0, "brk_pfx");
    send(8'h1C, "brk1c");
    chk("brk1c.held", 32'(held_cnt), 0);

    send(8'hE0, "e0");
    send(8'h75, "mk_e075");
    chk("mk_e075.ext", 32'(evt_ext), 1);
    send(8'hF0, "f0");
    send(8'h75, "brk75_plain");
    chk("brk75_plain.held", 32'(held_cnt), 1);
    send(8'hE0, "e0b");
    send(8'hF0, "e0f0");
    send(8'h75, "brk_e075");
    chk("brk_e075.held", 32'(held_cnt), 0);

    do_reset("rst_fill");
    send(8'h1C, "fill1");
    send(8'h1B, "fill2");
    send(8'h23, "fill3");
    send(8'h2B, "fill4");
    send(8'h34, "fill5");
    chk("fill5.ovf", 32'(overflow), 1);
    chk("fill5.press", 32'(press_cnt), 5);
    chk("fill5.held", 32'(held_cnt), 4);
    send(8'hF0, "rel_pfx");
    send(8'h1B, "rel1b");
    send(8'h34, "ins34");
    chk("ins34.held", 32'(held_cnt), 4);
    tick(1'b0, 8'h00, 1'b1, "clr_ovf");
    chk("clr_ovf.ovf", 32'(overflow), 0);
    send(8'hF0, "rel34_pfx");
    send(8'h34, "rel34");
    send(8'h2B, "reins2b");

    do_reset("rst_to");
    send(8'hF0, "to_pfx");
    idle(TO, "to_wait");
    send(8'h1C, "to_mk");
    chk("to_mk.brk", 32'(evt_break), 0);
    chk("to_mk.press", 32'(press_cnt), 1);
    send(8'hF0, "edge_pfx");
    idle(TO - 1, "edge_wait");
    send(8'h1C, "edge_brk");
    chk("edge_brk.brk", 32'(evt_break), 1);

    send(8'hE0, "mid_e0");
    send(8'hF0, "mid_f0");
    do_reset("rst_mid");
    send(8'h75, "post_rst");
    chk("post_rst.code", 32'(evt_code), 32'h75);
    chk("post_rst.ext", 32'(evt_ext), 0);

    for (int n = 0; n < 400; n++) begin
      int r = int'($urandom_range(0, 39));
      int gap = (r == 0) ? TO : (r == 1) ? TO - 1
              : int'($urandom_range(0, 2));
      repeat (gap)
        tick(1'b0, 8'($urandom), ($urandom_range(0, 15) == 0), "rnd_idle");
      send(pool[$urandom_range(0, 9)], "rnd_byte");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
